// File: rtl/opcode_issue_pkg.sv
// Shared constants for the opcode issue stage and the 5-to-32 decoder it feeds.
// The opcode field range lives here so both sides slice the instruction identically.
package opcode_issue_pkg;
    localparam int INSTR_W = 32;
    localparam int OPC_W   = 5;
    localparam int OPC_LSB = 27;
    localparam int OPC_MSB = OPC_LSB + OPC_W - 1;
endpackage

// File: rtl/opcode_issue_fifo.sv
// Instruction buffer: storage array, wrap-around pointers and an occupancy counter.
// The read port is combinational from the head so the issue register can load it directly.
module opcode_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end
endmodule

// File: rtl/opcode_issue.sv
// Buffers instruction words and issues one registered opcode/enable/operand per cycle
// to the opcode decoder, with ALU backpressure and pipeline flush.
module opcode_issue
    import opcode_issue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               alu_busy,
    input  logic               flush,
    output logic [OPC_W-1:0]   opcode,
    output logic               enable,
    output logic [OPC_LSB-1:0] operand,
    output logic [CW-1:0]      count
);
    // Handshake: a word transfers on any rising edge where in_valid && in_ready; in_ready
    // depends only on registered occupancy and flush, never on in_valid or alu_busy.
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [INSTR_W-1:0] head;

    assign in_ready = !full && !flush;
    assign push     = in_valid && in_ready;
    assign pop      = !flush && !alu_busy && !empty;

    opcode_issue_fifo #(
        .DEPTH(DEPTH),
        .W    (INSTR_W)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .flush(flush),
        .push (push),
        .pop  (pop),
        .wdata(in_instr),
        .rdata(head),
        .count(count),
        .full (full),
        .empty(empty)
    );

    // Opcode/operand hold whenever nothing new is issued; only enable marks live data.
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode  <= '0;
            operand <= '0;
            enable  <= 1'b0;
        end else if (flush) begin
            enable <= 1'b0;
        end else if (!alu_busy) begin
            enable <= pop;
            if (pop) begin
                opcode  <= head[OPC_MSB:OPC_LSB];
                operand <= head[OPC_LSB-1:0];
            end
        end
    end
endmodule

// File: tb/tb_opcode_issue.sv
// Directed bench for opcode_issue: reset, single issue, burst under backpressure,
// stall hold, flush, pointer wrap and mid-stream reset.
module tb_opcode_issue;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        alu_busy;
    logic        flush;
    logic [4:0]  opcode;
    logic        enable;
    logic [26:0] operand;
    logic [2:0]  count;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] w[6];
    logic [31:0] front;
    int idx;
    int n_iss;
    logic acc;

    opcode_issue #(.DEPTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_instr(in_instr),
        .in_ready(in_ready),
        .alu_busy(alu_busy),
        .flush   (flush),
        .opcode  (opcode),
        .enable  (enable),
        .operand (operand),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; alu_busy = 1'b0; flush = 1'b0;

        // reset then idle
        step(); step();
        check("rst_opcode", 32'(opcode), 32'h0);
        check("rst_enable", 32'(enable), 32'h0);
        check("rst_operand", 32'(operand), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;
        step();

        // single push, two-edge latency
        in_valid = 1'b1; in_instr = 32'h2800_0005;
        step();
        check("single_count_k", 32'(count), 32'h1);
        check("single_enable_k", 32'(enable), 32'h0);
        in_valid = 1'b0;
        step();
        check("single_opcode", 32'(opcode), 32'h05);
        check("single_operand", 32'(operand), 32'h0000005);
        check("single_enable", 32'(enable), 32'h1);
        check("single_count", 32'(count), 32'h0);
        step();
        check("single_enable_off", 32'(enable), 32'h0);
        check("single_count_off", 32'(count), 32'h0);

        // burst of 6 under backpressure
        for (int i = 0; i < 6; i++) w[i] = (32'(i) << 27) | (32'h100 + 32'(i));
        alu_busy = 1'b1;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_instr = w[idx];
            acc = in_ready;
            step();
            if (acc) begin exp_q.push_back(w[idx]); idx++; end
            check("burst_busy_enable", 32'(enable), 32'h0);
        end
        check("burst_full_count", 32'(count), 32'h4);
        check("burst_full_ready", 32'(in_ready), 32'h0);
        check("burst_accepted", 32'(idx), 32'h4);
        alu_busy = 1'b0;
        n_iss = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = (idx < 6);
            if (idx < 6) in_instr = w[idx];
            acc = in_valid && in_ready;
            step();
            if (acc) begin exp_q.push_back(w[idx]); idx++; end
            check("burst_enable_seq", 32'(enable), (c < 6) ? 32'h1 : 32'h0);
            if (enable && exp_q.size() > 0) begin
                front = exp_q.pop_front();
                check("burst_opcode", 32'(opcode), 32'(front[31:27]));
                check("burst_operand", 32'(operand), 32'(front[26:0]));
                n_iss++;
            end
        end
        check("burst_issued", 32'(n_iss), 32'h6);
        in_valid = 1'b0;

        // stall mid-stream holds opcode 7
        in_valid = 1'b1; in_instr = 32'h3800_0077;
        step();
        in_instr = 32'h4000_0088;
        step();
        check("stall_first_opcode", 32'(opcode), 32'h07);
        in_valid = 1'b0; alu_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall_hold_opcode", 32'(opcode), 32'h07);
            check("stall_hold_enable", 32'(enable), 32'h1);
            check("stall_hold_operand", 32'(operand), 32'h77);
        end
        alu_busy = 1'b0;
        step();
        check("stall_next_opcode", 32'(opcode), 32'h08);
        check("stall_next_enable", 32'(enable), 32'h1);
        step();
        check("stall_drain_enable", 32'(enable), 32'h0);

        // flush with count=3, enable=1, and a push attempt
        alu_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_instr = (32'(9 + i) << 27) | 32'h200;
            step();
        end
        alu_busy = 1'b0; in_valid = 1'b0;
        step();
        check("flush_pre_count", 32'(count), 32'h3);
        check("flush_pre_enable", 32'(enable), 32'h1);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'hF800_00FF;
        step();
        check("flush_count", 32'(count), 32'h0);
        check("flush_enable", 32'(enable), 32'h0);
        check("flush_opcode_hold", 32'(opcode), 32'h09);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_in_ready", 32'(in_ready), 32'h1);
        step();
        check("flush_discard_enable", 32'(enable), 32'h0);
        check("flush_discard_count", 32'(count), 32'h0);

        // pointer wrap at full rate
        exp_q.delete();
        n_iss = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 10);
            in_instr = (32'(c + 16) << 27) | (32'h1000 + 32'(c));
            acc = in_valid && in_ready;
            if (acc) exp_q.push_back(in_instr);
            step();
            check("wrap_count_le1", 32'(count <= 3'd1), 32'h1);
            if (enable) begin
                if (exp_q.size() > 0) front = exp_q.pop_front();
                else front = 32'hFFFF_FFFF;
                check("wrap_opcode", 32'(opcode), 32'(front[31:27]));
                check("wrap_operand", 32'(operand), 32'(front[26:0]));
                n_iss++;
            end
        end
        check("wrap_issued", 32'(n_iss), 32'd10);
        in_valid = 1'b0;

        // reset mid-stream discards everything
        alu_busy = 1'b1;
        in_valid = 1'b1; in_instr = 32'h5000_0001;
        step(); step();
        rst = 1'b1; in_instr = 32'h5800_0002;
        step();
        check("mrst_count", 32'(count), 32'h0);
        check("mrst_enable", 32'(enable), 32'h0);
        check("mrst_opcode", 32'(opcode), 32'h0);
        check("mrst_operand", 32'(operand), 32'h0);
        rst = 1'b0; in_valid = 1'b0; alu_busy = 1'b0;
        step();
        check("mrst_after_enable", 32'(enable), 32'h0);
        check("mrst_after_count", 32'(count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
